itrx_amba4_axi_reg_slice: RTL

- Parametrised AMBA4 AXI register slice: one independent pipeline stage per channel (AW, W, B, AR, R) between a slave-side port (s_*, faces the master) and a master-side port (m_*, faces the slave).
- Each channel's mode is set by a parameter: bypass, forward-registered, or full skid buffer.
- Breaks timing paths on long interconnect routes and reports slice occupancy via cactive for the low-power handshake.

---
 rtl/itrx_amba4_axi_pkg.sv | 53 +++++
 rtl/itrx_axi_chan_slice.sv | 131 +++++++++++++
 rtl/itrx_amba4_axi_reg_slice.sv | 122 ++++++++++++
 3 files changed

// File: rtl/itrx_amba4_axi_pkg.sv
// Shared AXI4 types and constants for the itrx register slice.
// The address payload width is derived from the field types so it tracks any field change.
package itrx_amba4_axi_pkg;

  localparam int XIDW   = 4;
  localparam int XADDRW = 32;

  typedef logic [XIDW-1:0]   t_xid;
  typedef logic [XADDRW-1:0] t_xaddr;
  typedef logic [7:0]        t_xlen;
  typedef logic [3:0]        t_xcache;
  typedef logic [3:0]        t_xqos;
  typedef logic [3:0]        t_xregion;

  typedef enum logic [2:0] {
    SIZE_1B, SIZE_2B, SIZE_4B, SIZE_8B, SIZE_16B, SIZE_32B, SIZE_64B, SIZE_128B
  } te_xsize;

  typedef enum logic [1:0] {
    BURST_FIXED, BURST_INCR, BURST_WRAP, BURST_RSVD
  } te_xburst;

  typedef struct packed {
    logic instr;
    logic nonsec;
    logic priv;
  } ts_xprot;

  typedef struct packed {
    t_xid     id;
    t_xaddr   addr;
    t_xlen    len;
    te_xsize  size;
    te_xburst burst;
    t_xcache  cache;
    ts_xprot  prot;
    t_xqos    qos;
    t_xregion region;
  } ts_xapld;

  localparam int XAPLDW = $bits(ts_xapld);

  localparam int AXI_RS_BYPASS = 0;
  localparam int AXI_RS_FWD    = 1;
  localparam int AXI_RS_FULL   = 2;

  typedef enum logic [1:0] {
    RS_EMPTY,
    RS_ONE,
    RS_FULL
  } te_rs_state;

endpackage

// File: rtl/itrx_axi_chan_slice.sv
// One valid/ready pipeline stage carrying an opaque payload.
// MODE selects bypass wires, a forward register, or a two-entry skid buffer.
module itrx_axi_chan_slice
  import itrx_amba4_axi_pkg::*;
#(
  parameter int PLDW = 8,
  parameter int MODE = AXI_RS_FULL
) (
  input  logic            aclk,
  input  logic            areset_n,
  input  logic [PLDW-1:0] s_pld,
  input  logic            s_valid,
  output logic            s_ready,
  output logic [PLDW-1:0] m_pld,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            busy
);

  if (MODE == AXI_RS_BYPASS) begin : g_bypass
    logic unused_clk_rst;

    assign unused_clk_rst = aclk ^ areset_n;
    assign m_pld   = s_pld;
    assign m_valid = s_valid;
    assign s_ready = m_ready;
    assign busy    = 1'b0;

  end else if (MODE == AXI_RS_FWD) begin : g_fwd
    logic            valid_q, valid_d;
    logic [PLDW-1:0] pld_q, pld_d;
    logic            push;

    always_comb begin
      push    = s_valid && s_ready;
      valid_d = valid_q;
      pld_d   = pld_q;
      if (push) begin
        valid_d = 1'b1;
        pld_d   = s_pld;
      end else if (m_ready) begin
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
        valid_q <= 1'b0;
        pld_q   <= '0;
      end else begin
        valid_q <= valid_d;
        pld_q   <= pld_d;
      end
    end

    // Ready looks through the register so a draining slot can refill in the same cycle.
    assign s_ready = !valid_q || m_ready;
    assign m_valid = valid_q;
    assign m_pld   = pld_q;
    assign busy    = valid_q;

  end else if (MODE == AXI_RS_FULL) begin : g_full
    te_rs_state      state_q, state_d;
    logic [PLDW-1:0] main_q, main_d;
    logic [PLDW-1:0] skid_q, skid_d;
    logic            s_ready_q, s_ready_d;
    logic            m_valid_q, m_valid_d;
    logic            push, pop;

    always_comb begin
      push    = s_valid && s_ready_q;
      pop     = m_valid_q && m_ready;
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
        RS_EMPTY: begin
          if (push) begin
            state_d = RS_ONE;
            main_d  = s_pld;
          end
        end
        RS_ONE: begin
          if (push && !pop) begin
            state_d = RS_FULL;
            skid_d  = s_pld;
          end else if (push && pop) begin
            main_d = s_pld;
          end else if (pop) begin
            state_d = RS_EMPTY;
          end
        end
        RS_FULL: begin
          if (pop) begin
            state_d = RS_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = RS_EMPTY;
      endcase
      // Both handshake outputs are registered images of the next state.
      s_ready_d = (state_d != RS_FULL);
      m_valid_d = (state_d != RS_EMPTY);
    end

    always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
        state_q   <= RS_EMPTY;
        main_q    <= '0;
        skid_q    <= '0;
        s_ready_q <= 1'b1;
        m_valid_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        main_q    <= main_d;
        skid_q    <= skid_d;
        s_ready_q <= s_ready_d;
        m_valid_q <= m_valid_d;
      end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_pld   = main_q;
    assign busy    = m_valid_q;

  end else begin : g_bad_mode
    $error("itrx_axi_chan_slice: MODE must be 0, 1 or 2");
  end

endmodule

// File: rtl/itrx_amba4_axi_reg_slice.sv
// AXI4 register slice: one independently configured stage per channel.
// B and R run slave-to-master, so their slices are wired in the reverse direction.
module itrx_amba4_axi_reg_slice
  import itrx_amba4_axi_pkg::*;
#(
  parameter int XDATAW  = 64,
  parameter int AWUSERW = 1,
  parameter int WUSERW  = 1,
  parameter int BUSERW  = 1,
  parameter int ARUSERW = 1,
  parameter int RUSERW  = 1,
  parameter int AW_MODE = AXI_RS_FULL,
  parameter int W_MODE  = AXI_RS_FULL,
  parameter int B_MODE  = AXI_RS_FULL,
  parameter int AR_MODE = AXI_RS_FULL,
  parameter int R_MODE  = AXI_RS_FULL,
  localparam int XSTRBW = XDATAW / 8
) (
  input  logic                                  aclk,
  input  logic                                  areset_n,
  input  logic [XAPLDW+AWUSERW-1:0]             s_awpld,
  input  logic                                  s_awvalid,
  output logic                                  s_awready,
  output logic [XAPLDW+AWUSERW-1:0]             m_awpld,
  output logic                                  m_awvalid,
  input  logic                                  m_awready,
  input  logic [XDATAW+XSTRBW+1+WUSERW-1:0]     s_wpld,
  input  logic                                  s_wvalid,
  output logic                                  s_wready,
  output logic [XDATAW+XSTRBW+1+WUSERW-1:0]     m_wpld,
  output logic                                  m_wvalid,
  input  logic                                  m_wready,
  input  logic [XIDW+2+BUSERW-1:0]              m_bpld,
  input  logic                                  m_bvalid,
  output logic                                  m_bready,
  output logic [XIDW+2+BUSERW-1:0]              s_bpld,
  output logic                                  s_bvalid,
  input  logic                                  s_bready,
  input  logic [XAPLDW+ARUSERW-1:0]             s_arpld,
  input  logic                                  s_arvalid,
  output logic                                  s_arready,
  output logic [XAPLDW+ARUSERW-1:0]             m_arpld,
  output logic                                  m_arvalid,
  input  logic                                  m_arready,
  input  logic [XIDW+XDATAW+2+1+RUSERW-1:0]     m_rpld,
  input  logic                                  m_rvalid,
  output logic                                  m_rready,
  output logic [XIDW+XDATAW+2+1+RUSERW-1:0]     s_rpld,
  output logic                                  s_rvalid,
  input  logic                                  s_rready,
  output logic                                  cactive
);

  logic aw_busy, w_busy, b_busy, ar_busy, r_busy;

  itrx_axi_chan_slice #(.PLDW(XAPLDW + AWUSERW), .MODE(AW_MODE)) u_aw (
    .aclk    (aclk),
    .areset_n(areset_n),
    .s_pld   (s_awpld),
    .s_valid (s_awvalid),
    .s_ready (s_awready),
    .m_pld   (m_awpld),
    .m_valid (m_awvalid),
    .m_ready (m_awready),
    .busy    (aw_busy)
  );

  itrx_axi_chan_slice #(.PLDW(XDATAW + XSTRBW + 1 + WUSERW), .MODE(W_MODE)) u_w (
    .aclk    (aclk),
    .areset_n(areset_n),
    .s_pld   (s_wpld),
    .s_valid (s_wvalid),
    .s_ready (s_wready),
    .m_pld   (m_wpld),
    .m_valid (m_wvalid),
    .m_ready (m_wready),
    .busy    (w_busy)
  );

  itrx_axi_chan_slice #(.PLDW(XIDW + 2 + BUSERW), .MODE(B_MODE)) u_b (
    .aclk    (aclk),
    .areset_n(areset_n),
    .s_pld   (m_bpld),
    .s_valid (m_bvalid),
    .s_ready (m_bready),
    .m_pld   (s_bpld),
    .m_valid (s_bvalid),
    .m_ready (s_bready),
    .busy    (b_busy)
  );

  itrx_axi_chan_slice #(.PLDW(XAPLDW + ARUSERW), .MODE(AR_MODE)) u_ar (
    .aclk    (aclk),
    .areset_n(areset_n),
    .s_pld   (s_arpld),
    .s_valid (s_arvalid),
    .s_ready (s_arready),
    .m_pld   (m_arpld),
    .m_valid (m_arvalid),
    .m_ready (m_arready),
    .busy    (ar_busy)
  );

  itrx_axi_chan_slice #(.PLDW(XIDW + XDATAW + 2 + 1 + RUSERW), .MODE(R_MODE)) u_r (
    .aclk    (aclk),
    .areset_n(areset_n),
    .s_pld   (m_rpld),
    .s_valid (m_rvalid),
    .s_ready (m_rready),
    .m_pld   (s_rpld),
    .m_valid (s_rvalid),
    .m_ready (s_rready),
    .busy    (r_busy)
  );

  // Any held beat or pending request keeps the clock-gating handshake from stopping aclk.
  always_comb begin
    cactive = aw_busy || w_busy || b_busy || ar_busy || r_busy ||
              s_awvalid || s_wvalid || s_arvalid || m_bvalid || m_rvalid;
  end

endmodule
